// File: rtl/shift_unit_iter.sv
// Multi-cycle shift/rotate unit: SLL/SRL/SRA/ROR, at most STEP bit positions per clock,
// valid/ready on both sides with synchronous flush. Includes the ALU opcode subset it decodes.
package cv32e40p_pkg;
  parameter int ALU_OP_WIDTH = 7;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD = 7'b0011000,
    ALU_SUB = 7'b0011001,
    ALU_XOR = 7'b0101111,
    ALU_OR  = 7'b0101110,
    ALU_AND = 7'b0010101,
    ALU_SRA = 7'b0100100,
    ALU_SRL = 7'b0100101,
    ALU_ROR = 7'b0100110,
    ALU_SLL = 7'b0100111
  } alu_opcode_e;
endpackage

module shift_unit_iter
  import cv32e40p_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  alu_opcode_e              operator_i,
  input  logic [WIDTH-1:0]         operand_a_i,
  input  logic [$clog2(WIDTH)-1:0] shamt_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WIDTH-1:0]         result_o
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [SW:0] STEP_W  = (SW+1)'(STEP);
  localparam logic [SW:0] WIDTH_W = (SW+1)'(WIDTH);

  logic [1:0]       r_state;
  alu_opcode_e      r_op;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_rem;

  logic [SW:0]      w_k;
  logic [SW-1:0]    w_rem_nxt;
  logic [WIDTH-1:0] w_step;
  logic             w_supp;

  function automatic logic is_supported(input alu_opcode_e op);
    logic ok;
    ok = 1'b0;
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROR: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // One partial step; k is never 0 in SHIFT, and SRA keeps the original sign because the MSB never changes.
  function automatic logic [WIDTH-1:0] shift_by(input alu_opcode_e op,
                                                input logic [WIDTH-1:0] d,
                                                input logic [SW:0] k);
    logic [WIDTH-1:0] res;
    res = d;
    case (op)
      ALU_SLL: res = d << k;
      ALU_SRL: res = d >> k;
      ALU_SRA: res = $signed(d) >>> k;
      ALU_ROR: res = (d >> k) | (d << (WIDTH_W - k));
      default: res = d;
    endcase
    return res;
  endfunction

  always_comb begin
    w_k       = ({1'b0, r_rem} > STEP_W) ? STEP_W : {1'b0, r_rem};
    w_rem_nxt = r_rem - w_k[SW-1:0];
    w_step    = shift_by(r_op, r_data, w_k);
    w_supp    = is_supported(operator_i);
  end

  assign ready_o  = rst_n && (r_state == IDLE);
  assign valid_o  = (r_state == DONE);
  assign result_o = r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= ALU_SLL;
      r_data  <= '0;
      r_rem   <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_op   <= operator_i;
            r_data <= operand_a_i;
            r_rem  <= w_supp ? shamt_i : '0;
            r_state <= (shamt_i == '0 || !w_supp) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_data <= w_step;
          r_rem  <= w_rem_nxt;
          if (w_rem_nxt == '0) r_state <= DONE;
        end
        DONE: begin
          if (ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_unit_iter.md
# shift_unit_iter

Parametrised, multi-cycle shift/rotate unit for the ALU datapath. It supports logical left, logical right, arithmetic right and rotate right, and processes at most STEP bit positions per clock. It has a valid/ready handshake on both sides, with backpressure and a synchronous flush. It is the area-reduced, width-generic shift path for configurations that do not want a full single-cycle barrel shifter.

## Interface
Parameters:
- WIDTH, default 32: operand/result width; power of 2, ≥ 8.
- STEP, default 4: maximum bit positions shifted per cycle; power of 2, 1 ≤ STEP ≤ WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- flush_i  input  1  synchronous abort of any in-flight operation.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- operator_i  input  alu_opcode_e (cv32e40p_pkg, ALU_OP_WIDTH bits)  operation select.
- operand_a_i  input  WIDTH  value to shift.
- shamt_i  input  $clog2(WIDTH)  shift/rotate amount, unsigned.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  shifted result; registered.

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset state is IDLE.
- ready_o = (state == IDLE) while rst_n is high. valid_o = (state == DONE).
- **IDLE:** on valid_i && ready_o, latch operator_i, operand_a_i and shamt_i into internal registers (remaining = shamt_i).
  - If shamt_i == 0 or the opcode is unsupported, go to DONE.
  - Otherwise go to SHIFT.
- **SHIFT:** each cycle shift the data register by k = min(remaining, STEP), then set remaining -= k.
  - When the new remaining == 0, go to DONE.
- **DONE:** hold result_o and valid_o. On ready_i, go to IDLE.
  - No new request is accepted in DONE. valid_i is ignored outside IDLE.
- Supported opcodes: ALU_SLL, ALU_SRL, ALU_SRA and ALU_ROR.
  - SLL and SRL zero-fill.
  - SRA fills with bit WIDTH-1 of the latched operand.
  - ROR re-enters shifted-out LSBs at the MSB.
- Any other opcode passes operand_a through unchanged with latency 1.
- The final result equals the single-step reference: SLL a<<s, SRL a>>s, SRA $signed(a)>>>s, ROR (a>>s)|(a<<(WIDTH-s)) for s>0.
- shamt_i is always < WIDTH, so there is no modulo handling. The maximum amount is WIDTH-1.
- **flush_i:** in any state, the next state is IDLE and valid_o drops on the next cycle. Data registers keep their value but are don't-care.
  - A flush in IDLE with valid_i high accepts nothing.
- **Priority:** rst_n low > flush_i > handshake/FSM.

## Timing
- N = ceil(shamt/STEP) for supported opcodes; N = 0 for shamt == 0 or an unsupported opcode.
- Call the handshake cycle (valid_i && ready_o sampled high) cycle 0. valid_o is first high in cycle N+1.
  - Example, WIDTH=32, STEP=4: shamt=31 gives valid_o in cycle 9.
- Throughput is one operation per N+2 cycles with ready_i held high: DONE→IDLE costs one cycle.
- result_o and valid_o are stable while valid_o && !ready_i, for any length of stall.
- Reset values, held while rst_n is low and on the first cycle after release: state=IDLE, valid_o=0, result_o=0, remaining=0.
  - ready_o is 0 while rst_n is low and 1 from the first cycle after release.
- Reset or flush mid-SHIFT abandons the operation. No valid_o pulse appears for it.
- Simultaneous ready_i and flush_i in DONE: the result counts as consumed, state goes to IDLE.

## Test plan
All values at WIDTH=32, STEP=4.
- **SRA:** a=0x8000_0004, shamt=1 → result 0xC000_0002, valid_o in cycle 2. SRA a=4, shamt=1 → 0x2.
- **SRL:** a=4, shamt=1 → 0x2. SRL a=0x8000_0000, shamt=31 → 0x1, valid_o in cycle 9.
- **ROR:** a=5, shamt=1 → 0x8000_0002. ROR a=5, shamt=0 → 0x5, valid_o in cycle 1.
- **SLL and unsupported opcode:** SLL a=5, shamt=2 → 0x14. SLL a=1, shamt=10 → 0x400, valid_o in cycle 4. ALU_ADD a=0x1234, shamt=7 → 0x1234, valid_o in cycle 1.
- **Backpressure:** ready_i low for 5 cycles in DONE.
  - result_o and valid_o stay constant; ready_o stays 0.
  - A valid_i pulse during the stall is not accepted.
  - After ready_i rises, ready_o is 1 the next cycle.
- **Abort:** flush_i in cycle 3 of SLL shamt=31 → valid_o never rises, ready_o=1 in cycle 4; a following SRL a=4, shamt=1 → 0x2. Repeat with rst_n low for 1 cycle mid-SHIFT → all outputs at reset values, same recovery.
